// File: rtl/mux4a1_sched_ctrl.sv
// Lane scheduler for the two-level 4:1 byte mux tree: picks the forwarded lane,
// drives the L1/L2 selectors and returns a one-hot pop to the consumed lane.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not scheduling; selectors hold, no grants
// ALIGN | strict mode only: waiting for lane 0 to start a frame
// RUN   | scheduling (strict frame order or skip round-robin)
module mux4a1_sched_ctrl #(
    parameter int CNT_W    = 8,
    parameter int IDLE_MAX = 15
) (
    input  logic             clk_4f,
    input  logic             reset_L,
    input  logic             enable,
    input  logic             mode,
    input  logic             valid0,
    input  logic             valid1,
    input  logic             valid2,
    input  logic             valid3,
    output logic             selectorL1,
    output logic             selectorL2,
    output logic             validout,
    output logic [3:0]       pop,
    output logic [CNT_W-1:0] grant_cnt,
    output logic             timeout,
    output logic             busy
);

    localparam int WD_W = 5;
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(IDLE_MAX);
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        last_q, last_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [1:0]        sel_q, sel_d;
    logic              validout_q;
    logic [3:0]        pop_q, pop_d;
    logic [CNT_W-1:0]  grant_cnt_q, grant_cnt_d;
    logic              timeout_q, timeout_d;
    logic              busy_q;

    logic [3:0]        valid_vec;
    logic [3:0]        avail;
    logic              found;
    logic [1:0]        found_lane;
    logic [1:0]        cand;
    logic              grant;
    logic [1:0]        lane;

    assign valid_vec = {valid3, valid2, valid1, valid0};
    // The lane popped last cycle still shows valid until upstream sees the pop.
    assign avail     = valid_vec & ~pop_q;

    always_comb begin
        found      = 1'b0;
        found_lane = last_q;
        cand       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && avail[cand]) begin
                found      = 1'b1;
                found_lane = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        ptr_d     = ptr_q;
        last_d    = last_q;
        wd_d      = wd_q;
        sel_d     = sel_q;
        grant     = 1'b0;
        lane      = 2'd0;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                wd_d  = '0;
                ptr_d = 2'd0;
                if (enable) begin
                    mode_d  = mode;
                    state_d = mode ? S_RUN : S_ALIGN;
                end
            end
            S_ALIGN: begin
                wd_d = '0;
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (valid0) begin
                    grant   = 1'b1;
                    lane    = 2'd0;
                    ptr_d   = 2'd1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!mode_q) begin
                    lane  = ptr_q;
                    sel_d = ptr_q;
                    grant = valid_vec[ptr_q];
                    ptr_d = ptr_q + 2'd1;
                    if (!enable && ptr_q == 2'd3)
                        state_d = S_IDLE;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end else if (found) begin
                    grant  = 1'b1;
                    lane   = found_lane;
                    last_d = found_lane;
                end

                // Watchdog expiry overrides frame completion; a grant always clears it.
                if (grant) begin
                    wd_d = '0;
                end else if (wd_q + WD_ONE == WD_MAX) begin
                    wd_d      = '0;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
                if (state_d != S_RUN)
                    wd_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (grant)
            sel_d = lane;
        pop_d       = grant ? (4'b0001 << lane) : 4'b0000;
        grant_cnt_d = grant ? grant_cnt_q + CNT_ONE : grant_cnt_q;
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            ptr_q       <= 2'd0;
            last_q      <= 2'd0;
            wd_q        <= '0;
            sel_q       <= 2'd0;
            validout_q  <= 1'b0;
            pop_q       <= 4'b0000;
            grant_cnt_q <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            wd_q        <= wd_d;
            sel_q       <= sel_d;
            validout_q  <= grant;
            pop_q       <= pop_d;
            grant_cnt_q <= grant_cnt_d;
            timeout_q   <= timeout_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign selectorL1 = sel_q[0];
    assign selectorL2 = sel_q[1];
    assign validout   = validout_q;
    assign pop        = pop_q;
    assign grant_cnt  = grant_cnt_q;
    assign timeout    = timeout_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mux4a1_sched_ctrl.sv
// Directed bench for mux4a1_sched_ctrl: strict framing, bubbles, stop, skip
// round-robin, watchdog timeout and asynchronous reset.
module tb_mux4a1_sched_ctrl;

    logic       clk_4f;
    logic       reset_L;
    logic       enable;
    logic       mode;
    logic       valid0, valid1, valid2, valid3;
    logic       selectorL1, selectorL2, validout;
    logic [3:0] pop;
    logic [7:0] grant_cnt;
    logic       timeout, busy;

    int n_vec;
    int n_err;

    mux4a1_sched_ctrl #(.CNT_W(8), .IDLE_MAX(15)) dut (
        .clk_4f     (clk_4f),
        .reset_L    (reset_L),
        .enable     (enable),
        .mode       (mode),
        .valid0     (valid0),
        .valid1     (valid1),
        .valid2     (valid2),
        .valid3     (valid3),
        .selectorL1 (selectorL1),
        .selectorL2 (selectorL2),
        .validout   (validout),
        .pop        (pop),
        .grant_cnt  (grant_cnt),
        .timeout    (timeout),
        .busy       (busy)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {sel[1:0], validout, pop[3:0]}
    task automatic chk_out(input string tag, input logic [1:0] sel, input logic vo, input logic [3:0] p);
        chk(tag, {25'd0, selectorL2, selectorL1, validout, pop}, {25'd0, sel, vo, p});
    endtask

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic set_valid(input logic [3:0] v);
        {valid3, valid2, valid1, valid0} = v;
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        mode    = 1'b0;
        set_valid(4'b0000);
        @(negedge clk_4f);
        reset_L = 1'b0;
        @(negedge clk_4f);
        reset_L = 1'b1;
    endtask

    initial begin
        logic [1:0] l;
        n_vec   = 0;
        n_err   = 0;
        reset_L = 1'b1;

        // reset state
        do_reset();
        chk_out("rst_out", 2'b00, 1'b0, 4'b0000);
        chk("rst_cnt", {24'd0, grant_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_to", {31'd0, timeout}, 32'd0);

        // strict, all valid: ALIGN passes, then 0,1,2,3 repeating; 256 words wraps count
        set_valid(4'b1111);
        enable = 1'b1;
        mode   = 1'b0;
        tick();
        chk("s_align_busy", {31'd0, busy}, 32'd1);
        chk_out("s_align_out", 2'b00, 1'b0, 4'b0000);
        tick();
        chk_out("s_w0", 2'b00, 1'b1, 4'b0001);
        chk("s_cnt1", {24'd0, grant_cnt}, 32'd1);
        for (int i = 1; i < 256; i++) begin
            tick();
            if (i < 8 || i >= 252) begin
                l = 2'(i % 4);
                chk_out($sformatf("s_w%0d", i), l, 1'b1, 4'b0001 << l);
            end
        end
        chk("s_cnt_wrap", {24'd0, grant_cnt}, 32'd0);

        // strict with lane 2 missing: bubble in its slot
        do_reset();
        set_valid(4'b1011);
        enable = 1'b1;
        tick();
        tick();
        chk_out("b_l0", 2'b00, 1'b1, 4'b0001);
        tick();
        chk_out("b_l1", 2'b01, 1'b1, 4'b0010);
        tick();
        chk_out("b_l2_bubble", 2'b10, 1'b0, 4'b0000);
        tick();
        chk_out("b_l3", 2'b11, 1'b1, 4'b1000);
        chk("b_cnt", {24'd0, grant_cnt}, 32'd3);
        tick();
        chk_out("b_l0_again", 2'b00, 1'b1, 4'b0001);

        // strict stop with ptr=2: lanes 2 and 3 still granted, then idle
        do_reset();
        set_valid(4'b1111);
        enable = 1'b1;
        tick();
        tick();
        chk_out("t_l0", 2'b00, 1'b1, 4'b0001);
        tick();
        chk_out("t_l1", 2'b01, 1'b1, 4'b0010);
        enable = 1'b0;
        tick();
        chk_out("t_l2", 2'b10, 1'b1, 4'b0100);
        chk("t_busy_l2", {31'd0, busy}, 32'd1);
        tick();
        chk_out("t_l3", 2'b11, 1'b1, 4'b1000);
        chk("t_busy_done", {31'd0, busy}, 32'd0);
        tick();
        chk_out("t_idle", 2'b11, 1'b0, 4'b0000);
        chk("t_cnt", {24'd0, grant_cnt}, 32'd4);

        // skip, lanes 1 and 3 valid: alternate 1,3,1,3
        do_reset();
        set_valid(4'b1010);
        mode   = 1'b1;
        enable = 1'b1;
        tick();
        chk("k_busy", {31'd0, busy}, 32'd1);
        chk_out("k_first_idle", 2'b00, 1'b0, 4'b0000);
        mode = 1'b0;
        tick();
        chk_out("k_g1a", 2'b01, 1'b1, 4'b0010);
        tick();
        chk_out("k_g3a", 2'b11, 1'b1, 4'b1000);
        tick();
        chk_out("k_g1b", 2'b01, 1'b1, 4'b0010);
        tick();
        chk_out("k_g3b", 2'b11, 1'b1, 4'b1000);
        // only lane 1 valid: one grant every other cycle
        set_valid(4'b0010);
        tick();
        chk_out("k_o1a", 2'b01, 1'b1, 4'b0010);
        tick();
        chk_out("k_o_gap", 2'b01, 1'b0, 4'b0000);
        tick();
        chk_out("k_o1b", 2'b01, 1'b1, 4'b0010);
        chk("k_cnt", {24'd0, grant_cnt}, 32'd6);

        // asynchronous reset between edges while running
        #2;
        reset_L = 1'b0;
        #1;
        chk_out("ar_out", 2'b00, 1'b0, 4'b0000);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_cnt", {24'd0, grant_cnt}, 32'd0);

        // skip with nothing valid: watchdog fires after 15 idle RUN cycles
        do_reset();
        mode   = 1'b1;
        enable = 1'b1;
        tick();
        chk("w_busy", {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk($sformatf("w_quiet%0d", i), {30'd0, timeout, busy}, {30'd0, 1'b0, 1'b1});
        end
        tick();
        chk("w_fire", {31'd0, timeout}, 32'd1);
        chk("w_idle_busy", {31'd0, busy}, 32'd0);
        chk_out("w_out", 2'b00, 1'b0, 4'b0000);
        enable = 1'b0;
        tick();
        chk("w_pulse_end", {30'd0, timeout, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
